serial_magnitude_comparator: RTL and testbench

Bit-serial unsigned magnitude comparator controller for WIDTH-bit operands. It latches A and B on a start request and walks the operands MSB-first, one bit per clock, through a single one-bit compare cell, chaining the less/equal/greater flags between cycles. It reports a one-cycle done pulse with registered results. It sits beside the combinational comparators and is used wherever operand width makes a parallel chain too costly.

---
 rtl/cmp_pkg.sv | 14 +
 rtl/cmp_bit_cell.sv | 18 +
 rtl/serial_magnitude_comparator.sv | 104 ++++++++++
 tb/tb_serial_magnitude_comparator.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared state encoding and flag reset values for the serial comparator
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic FLAG_L0 = 1'b0;
    localparam logic FLAG_E0 = 1'b1;
    localparam logic FLAG_G0 = 1'b0;

endpackage

// File: rtl/cmp_bit_cell.sv
// rtl/cmp_bit_cell.sv - one-bit magnitude compare cell with chained less/equal/greater flags
module cmp_bit_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic l,
    input  logic e,
    input  logic g,
    output logic l_next,
    output logic e_next,
    output logic g_next
);

    // Once a higher bit has decided the result, lower bits cannot change it.
    assign l_next = e ? (~a_bit & b_bit)  : l;
    assign e_next = e ? ~(a_bit ^ b_bit)  : e;
    assign g_next = e ? (a_bit & ~b_bit)  : g;

endmodule

// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - MSB-first bit-serial unsigned comparator; SERIAL_CMP_EARLY_EXIT_EN stops at first differing bit
module serial_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             less,
    output logic             equal,
    output logic             greater
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [IW-1:0]    idx;
    logic             l;
    logic             e;
    logic             g;
    logic             l_next;
    logic             e_next;
    logic             g_next;
    logic             last_bit;
    logic             exit_now;

    cmp_bit_cell u_cell (
        .a_bit  (a_r[idx]),
        .b_bit  (b_r[idx]),
        .l      (l),
        .e      (e),
        .g      (g),
        .l_next (l_next),
        .e_next (e_next),
        .g_next (g_next)
    );

    assign last_bit = (idx == '0);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    assign exit_now = last_bit || !e_next;
`else
    assign exit_now = last_bit;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (exit_now) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            idx     <= IDX_TOP;
            l       <= FLAG_L0;
            e       <= FLAG_E0;
            g       <= FLAG_G0;
            less    <= 1'b0;
            equal   <= 1'b0;
            greater <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                a_r <= a;
                b_r <= b;
                idx <= IDX_TOP;
                l   <= FLAG_L0;
                e   <= FLAG_E0;
                g   <= FLAG_G0;
            end else if (state == RUN) begin
                l   <= l_next;
                e   <= e_next;
                g   <= g_next;
                idx <= idx - 1'b1;
                // Results land on the edge into DONE so they are valid alongside done.
                if (exit_now) begin
                    less    <= l_next;
                    equal   <= e_next;
                    greater <= g_next;
                end
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - directed and random checks of serial_magnitude_comparator
module tb_serial_magnitude_comparator;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic             less;
    logic             equal;
    logic             greater;

    int checks = 0;
    int errors = 0;

    serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .less    (less),
        .equal   (equal),
        .greater (greater)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycles from accepted start to the done cycle.
    function automatic int exp_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int lat;
        lat = WIDTH + 1;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        for (int i = 0; i < WIDTH; i++)
            if (x[i] != y[i]) lat = 1 + (WIDTH - 1 - i) + 1;
`endif
        return lat;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        check({tag, "_less"},    less,    x < y);
        check({tag, "_equal"},   equal,   x == y);
        check({tag, "_greater"}, greater, x > y);
    endtask

    // Called in an IDLE cycle; returns in the IDLE cycle after done.
    task automatic run_compare(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int lat;
        lat = exp_lat(x, y);
        a = x;
        b = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = ~x;
        b = ~y;
        for (int cyc = 1; cyc <= lat; cyc++) begin
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_done"}, done, cyc == lat);
            if (cyc < lat) tick();
        end
        check_result(tag, x, y);
        tick();
        check({tag, "_idle_busy"}, busy, 1'b0);
        check({tag, "_idle_done"}, done, 1'b0);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        int               lat;

        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_less", less, 1'b0);
        check("rst_equal", equal, 1'b0);
        check("rst_greater", greater, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_compare("eq", 8'h5A, 8'h5A);
        run_compare("msb", 8'h80, 8'h7F);
        run_compare("lsb", 8'h00, 8'h01);

        // start held through the whole first compare and into the second
        lat = exp_lat(8'h03, 8'h02);
        a = 8'h03;
        b = 8'h02;
        start = 1'b1;
        for (int cyc = 1; cyc <= 2 * lat + 2; cyc++) begin
            tick();
            if (cyc == 13) start = 1'b0;
            check("hold_start_done", done, (cyc == lat) || (cyc == 2 * lat + 1));
            check("hold_start_busy", busy, (cyc != lat + 1) && (cyc != 2 * lat + 2));
            if (cyc == lat || cyc == 2 * lat + 1) check_result("hold_start", 8'h03, 8'h02);
        end
        start = 1'b0;

        // asynchronous reset in the middle of a compare
        a = 8'hAA;
        b = 8'h55;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 4; cyc++) tick();
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_less", less, 1'b0);
        check("midrst_equal", equal, 1'b0);
        check("midrst_greater", greater, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        run_compare("after_rst", 8'h10, 8'h20);

        run_compare("hold", 8'hF0, 8'h0F);
        for (int cyc = 0; cyc < 20; cyc++) begin
            tick();
            check("hold_greater", greater, 1'b1);
            check("hold_done", done, 1'b0);
        end

        for (int n = 0; n < 40; n++) begin
            ra = WIDTH'($urandom);
            rb = (n % 5 == 0) ? ra : WIDTH'($urandom);
            run_compare("rand", ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
